// File: rtl/soc_sram_responder_if.sv
// Instruction and data SRAM buses between the core (master) and the
// SoC memory responder (slave).
interface soc_sram_responder_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/soc_sram_responder.sv
// SoC memory responder: read-only instruction port and read/write data port
// onto one shared word RAM, plus a small CONF register block (LED, NUM,
// SWITCH, TIMER) on the data port. Both ports have a fixed 1-cycle read latency.
module soc_sram_responder #(
    parameter int          RAM_AW    = 16,
    parameter logic [31:0] CONF_BASE = 32'hBFAF_0000
) (
    input  logic                 clk,
    input  logic                 rst,       // asynchronous, active low
    soc_sram_responder_if.slave  sram,
    input  logic [15:0]          switch_i,
    output logic [15:0]          led_o,
    output logic [31:0]          num_o
);
    localparam int DEPTH = 1 << RAM_AW;

    logic [31:0]       r_mem [DEPTH];
    logic [15:0]       r_led;
    logic [31:0]       r_num;
    logic [31:0]       r_timer;

    logic              w_d_rd;
    logic              w_d_wr;
    logic              w_conf_hit;
    logic [13:0]       w_off;
    logic [RAM_AW-1:0] w_d_idx;
    logic [RAM_AW-1:0] w_i_idx;
    logic [31:0]       w_timer_inc;
    logic [31:0]       w_conf_rdata;
    logic              w_unused;

    assign w_d_rd      = sram.data_sram_en && (sram.data_sram_wen == 4'b0000);
    assign w_d_wr      = sram.data_sram_en && (sram.data_sram_wen != 4'b0000);
    assign w_conf_hit  = (sram.data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign w_off       = sram.data_sram_addr[15:2];
    assign w_d_idx     = sram.data_sram_addr[RAM_AW+1:2];
    assign w_i_idx     = sram.inst_sram_addr[RAM_AW+1:2];
    // Value the timer takes at this edge; a TIMER read returns this.
    assign w_timer_inc = r_timer + 32'd1;

    // Instruction write controls and sub-word address bits carry no meaning here.
    assign w_unused = ^{sram.inst_sram_wen, sram.inst_sram_wdata,
                        sram.inst_sram_addr, sram.data_sram_addr};

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++)
            if (be[k]) res[8*k +: 8] = new_v[8*k +: 8];
        return res;
    endfunction

    // RAM byte-lane writes from the data port; contents are never reset.
    always_ff @(posedge clk) begin
        if (w_d_wr && !w_conf_hit)
            for (int k = 0; k < 4; k++)
                if (sram.data_sram_wen[k])
                    r_mem[w_d_idx][8*k +: 8] <= sram.data_sram_wdata[8*k +: 8];
    end

    // CONF registers; the timer free-runs unless a write loads it this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led   <= '0;
            r_num   <= '0;
            r_timer <= '0;
        end else begin
            r_timer <= w_timer_inc;
            if (w_d_wr && w_conf_hit) begin
                case (w_off)
                    14'h0: r_led   <= byte_merge({16'b0, r_led}, sram.data_sram_wdata,
                                                 {2'b00, sram.data_sram_wen[1:0]})[15:0];
                    14'h1: r_num   <= byte_merge(r_num, sram.data_sram_wdata, sram.data_sram_wen);
                    14'h3: r_timer <= byte_merge(r_timer, sram.data_sram_wdata, sram.data_sram_wen);
                    default: ;
                endcase
            end
        end
    end

    // CONF read mux; unmapped offsets read as zero.
    always_comb begin
        w_conf_rdata = '0;
        case (w_off)
            14'h0: w_conf_rdata = {16'b0, r_led};
            14'h1: w_conf_rdata = r_num;
            14'h2: w_conf_rdata = {16'b0, switch_i};
            14'h3: w_conf_rdata = w_timer_inc;
            default: w_conf_rdata = '0;
        endcase
    end

    // Read-data registers; RAM reads see pre-write contents (read-first).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram.inst_sram_rdata <= '0;
            sram.data_sram_rdata <= '0;
        end else begin
            if (sram.inst_sram_en)
                sram.inst_sram_rdata <= r_mem[w_i_idx];
            if (w_d_rd)
                sram.data_sram_rdata <= w_conf_hit ? w_conf_rdata : r_mem[w_d_idx];
        end
    end

    assign led_o = r_led;
    assign num_o = r_num;
endmodule

// File: tb/tb_soc_sram_responder.sv
// Directed bench for soc_sram_responder: reset, byte writes, aliasing,
// read-first collision, CONF registers and timer wrap.
module tb_soc_sram_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] switch_i;
    logic [15:0] led_o;
    logic [31:0] num_o;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] rd;

    soc_sram_responder_if sram ();

    soc_sram_responder dut (
        .clk      (clk),
        .rst      (rst),
        .sram     (sram),
        .switch_i (switch_i),
        .led_o    (led_o),
        .num_o    (num_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // All driving happens at the falling edge; results are sampled at the next one.
    task automatic dwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        sram.data_sram_en    = 1'b1;
        sram.data_sram_wen   = be;
        sram.data_sram_addr  = a;
        sram.data_sram_wdata = d;
        @(negedge clk);
        sram.data_sram_en    = 1'b0;
        sram.data_sram_wen   = 4'h0;
    endtask

    task automatic dread(input logic [31:0] a, output logic [31:0] d);
        sram.data_sram_en   = 1'b1;
        sram.data_sram_wen  = 4'h0;
        sram.data_sram_addr = a;
        @(negedge clk);
        sram.data_sram_en   = 1'b0;
        d = sram.data_sram_rdata;
    endtask

    task automatic iread(input logic [31:0] a, output logic [31:0] d);
        sram.inst_sram_en   = 1'b1;
        sram.inst_sram_addr = a;
        @(negedge clk);
        sram.inst_sram_en   = 1'b0;
        d = sram.inst_sram_rdata;
    endtask

    initial begin
        switch_i             = 16'hA5A5;
        sram.inst_sram_en    = 1'b0;
        sram.inst_sram_wen   = 4'h0;
        sram.inst_sram_addr  = '0;
        sram.inst_sram_wdata = '0;
        sram.data_sram_en    = 1'b0;
        sram.data_sram_wen   = 4'h0;
        sram.data_sram_addr  = '0;
        sram.data_sram_wdata = '0;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_inst_rdata", sram.inst_sram_rdata, 32'h0);
        check("rst_data_rdata", sram.data_sram_rdata, 32'h0);
        check("rst_led", {16'h0, led_o}, 32'h0);
        check("rst_num", num_o, 32'h0);
        rst = 1'b1;
        dread(32'hBFAF_000C, rd);
        check("timer_first", rd, 32'h1);

        // Byte-lane write
        dwrite(32'h0000_0100, 32'h1122_3344, 4'hF);
        dwrite(32'h0000_0100, 32'hAABB_CCDD, 4'b0101);
        dread(32'h0000_0100, rd);
        check("byte_write", rd, 32'h11BB_33DD);
        @(negedge clk);
        check("rdata_hold_idle", sram.data_sram_rdata, 32'h11BB_33DD);
        dwrite(32'h0000_0104, 32'hCAFE_F00D, 4'hF);
        check("rdata_hold_write", sram.data_sram_rdata, 32'h11BB_33DD);
        dread(32'h0000_0104, rd);
        check("read_after_write", rd, 32'hCAFE_F00D);

        // Aliasing
        dwrite(32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
        iread(32'h0004_0040, rd);
        check("alias_inst", rd, 32'hDEAD_BEEF);

        // Instruction port never writes
        sram.inst_sram_wen   = 4'hF;
        sram.inst_sram_wdata = 32'h0;
        iread(32'h0000_0040, rd);
        sram.inst_sram_wen   = 4'h0;
        dread(32'h0000_0040, rd);
        check("inst_no_write", rd, 32'hDEAD_BEEF);

        // Read-first collision
        dwrite(32'h0000_0080, 32'h5, 4'hF);
        sram.inst_sram_en    = 1'b1;
        sram.inst_sram_addr  = 32'h0000_0080;
        sram.data_sram_en    = 1'b1;
        sram.data_sram_wen   = 4'hF;
        sram.data_sram_addr  = 32'h0000_0080;
        sram.data_sram_wdata = 32'h9;
        @(negedge clk);
        sram.inst_sram_en    = 1'b0;
        sram.data_sram_en    = 1'b0;
        sram.data_sram_wen   = 4'h0;
        check("collision_old", sram.inst_sram_rdata, 32'h5);
        iread(32'h0000_0080, rd);
        check("collision_new", rd, 32'h9);

        // LED / NUM
        dwrite(32'hBFAF_0000, 32'hFFFF_1234, 4'hF);
        check("led_write", {16'h0, led_o}, 32'h0000_1234);
        dread(32'hBFAF_0000, rd);
        check("led_read", rd, 32'h0000_1234);
        dwrite(32'hBFAF_0004, 32'h1234_5678, 4'hF);
        dwrite(32'hBFAF_0004, 32'hAABB_CCDD, 4'b1000);
        check("num_byte", num_o, 32'hAA34_5678);
        dwrite(32'hBFAF_0000, 32'h0000_5600, 4'b1110);
        check("led_lane1_only", {16'h0, led_o}, 32'h0000_5634);

        // Timer load and wrap
        dwrite(32'hBFAF_000C, 32'hFFFF_FFFE, 4'hF);
        dread(32'hBFAF_000C, rd);
        check("timer_pre_wrap", rd, 32'hFFFF_FFFF);
        dread(32'hBFAF_000C, rd);
        check("timer_wrap", rd, 32'h0000_0000);

        // SWITCH and unmapped offsets
        dread(32'hBFAF_0008, rd);
        check("switch_read", rd, 32'h0000_A5A5);
        dwrite(32'hBFAF_0008, 32'hFFFF_FFFF, 4'hF);
        dwrite(32'hBFAF_0100, 32'hFFFF_FFFF, 4'hF);
        check("ro_led_kept", {16'h0, led_o}, 32'h0000_5634);
        check("ro_num_kept", num_o, 32'hAA34_5678);
        dread(32'hBFAF_0100, rd);
        check("unmapped_read", rd, 32'h0);
        dread(32'hBFAF_0008, rd);
        check("switch_after_write", rd, 32'h0000_A5A5);
        dread(32'h0000_0100, rd);
        check("conf_no_ram_write", rd, 32'h11BB_33DD);

        // Instruction port never decodes CONF (0xBFAF0008 -> RAM index 0xC002)
        dwrite(32'h0003_0008, 32'h1234_5678, 4'hF);
        iread(32'hBFAF_0008, rd);
        check("inst_no_conf", rd, 32'h1234_5678);

        // Reset during an access
        sram.data_sram_en   = 1'b1;
        sram.data_sram_wen  = 4'h0;
        sram.data_sram_addr = 32'h0000_0100;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sram.data_sram_en = 1'b0;
        #1;
        check("rst_mid_data", sram.data_sram_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_data", sram.data_sram_rdata, 32'h0);
        check("post_rst_inst", sram.inst_sram_rdata, 32'h0);
        check("post_rst_led", {16'h0, led_o}, 32'h0);
        check("post_rst_num", num_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
